// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path.
//   SPI_DATA_WIDTH : bits per received symbol
//   SPI_DATA_DEPTH : symbols per SPI frame
//   SPI_FRAME_W    : bits per complete frame
//   SPI_FIFO_DEPTH : frames buffered between the SPI front end and the consumer
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 2;
  localparam int SPI_DATA_DEPTH = 16;
  localparam int SPI_FRAME_W    = SPI_DATA_WIDTH * SPI_DATA_DEPTH;
  localparam int SPI_FIFO_DEPTH = 4;

  typedef enum logic {UNPK_IDLE, UNPK_EMIT} unpk_state_t;

  typedef logic [SPI_FRAME_W-1:0] spi_frame_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational read of the head entry, so a frame
// written at one edge can be popped at the very next edge.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (pointers and count to 0)
//   push  : write wdata (ignored when full unless a pop happens the same cycle)
//   pop   : remove head entry (ignored when empty)
//   wdata : entry to write
//   rdata : current head entry (valid when !empty)
//   count : entries stored, 0..DEPTH
//   full  : count == DEPTH
//   empty : count == 0
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count_reg == CW'(DEPTH));
    empty   = (count_reg == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    do_push = push && (!full || do_pop);
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (!do_push && do_pop) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/spi_frame_unpacker.sv
// Buffers complete SPI frames in a small FIFO and replays each frame one
// symbol per transfer over a valid/ready stream, first-received symbol first.
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset; discards all frames
//   frame_valid : one-cycle pulse, frame_data holds a complete frame
//   frame_data  : frame, symbol 0 in the top DATA_WIDTH bits
//   sym_ready   : consumer accepts the current symbol
//   sym_valid   : sym_data/sym_index/sym_last are valid
//   sym_data    : current symbol
//   sym_index   : position of sym_data within its frame
//   sym_last    : current symbol is the final one of its frame
//   fifo_count  : frames buffered, excluding the frame being emitted
//   overflow    : sticky, a frame arrived while the FIFO was full
module spi_frame_unpacker
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int DATA_DEPTH = SPI_DATA_DEPTH,
  parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_valid,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] frame_data,
  input  logic                            sym_ready,
  output logic                            sym_valid,
  output logic [DATA_WIDTH-1:0]           sym_data,
  output logic [$clog2(DATA_DEPTH)-1:0]   sym_index,
  output logic                            sym_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int FW = DATA_WIDTH * DATA_DEPTH;
  localparam int IW = $clog2(DATA_DEPTH);

  unpk_state_t   state_reg;
  logic [FW-1:0] hold_reg;
  logic [IW-1:0] index_reg;
  logic          valid_reg;
  logic          last_reg;
  logic          overflow_reg;

  logic [FW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          xfer;

  always_comb begin
    xfer      = valid_reg && sym_ready;
    // Pop either to start emitting from idle, or to chain the next frame
    // straight behind the last symbol so the stream has no bubble.
    fifo_pop  = !fifo_empty && ((state_reg == UNPK_IDLE) || (xfer && last_reg));
    fifo_push = frame_valid && (!fifo_full || fifo_pop);
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (frame_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= UNPK_IDLE;
      hold_reg     <= '0;
      index_reg    <= '0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (frame_valid && !fifo_push) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        UNPK_IDLE: begin
          if (fifo_pop) begin
            hold_reg  <= fifo_rdata;
            index_reg <= '0;
            valid_reg <= 1'b1;
            last_reg  <= (DATA_DEPTH == 1);
            state_reg <= UNPK_EMIT;
          end
        end

        UNPK_EMIT: begin
          // Without a transfer everything holds, keeping the stall stable.
          if (xfer) begin
            if (!last_reg) begin
              hold_reg  <= hold_reg << DATA_WIDTH;
              index_reg <= index_reg + IW'(1);
              last_reg  <= (index_reg == IW'(DATA_DEPTH-2));
            end else if (fifo_pop) begin
              hold_reg  <= fifo_rdata;
              index_reg <= '0;
              last_reg  <= (DATA_DEPTH == 1);
            end else begin
              index_reg <= '0;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              state_reg <= UNPK_IDLE;
            end
          end
        end

        default: state_reg <= UNPK_IDLE;
      endcase
    end
  end

  assign sym_valid = valid_reg;
  assign sym_data  = hold_reg[FW-1 -: DATA_WIDTH];
  assign sym_index = index_reg;
  assign sym_last  = last_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_spi_frame_unpacker.sv
module tb_spi_frame_unpacker;

  localparam int DW = 2;
  localparam int DD = 16;
  localparam int FW = DW * DD;
  localparam int FD = 4;

  typedef struct packed {
    logic       last;
    logic [3:0] idx;
    logic [1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          sym_ready;
  logic          sym_valid;
  logic [DW-1:0] sym_data;
  logic [3:0]    sym_index;
  logic          sym_last;
  logic [2:0]    fifo_count;
  logic          overflow;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  spi_frame_unpacker #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .sym_ready   (sym_ready),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .sym_index   (sym_index),
    .sym_last    (sym_last),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every accepted symbol must match the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && sym_valid && sym_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_symbol: got data=%0d index=%0d last=%0d, required no symbol",
                 sym_data, sym_index, sym_last);
      end else begin
        e = exp_q.pop_front();
        if ({sym_last, sym_index, sym_data} !== e) begin
          n_err++;
          $display("FAIL symbol: got data=%0d index=%0d last=%0d, required data=%0d index=%0d last=%0d",
                   sym_data, sym_index, sym_last, e.data, e.idx, e.last);
        end else begin
          $display("sym  data=%0d index=%0d last=%0d", sym_data, sym_index, sym_last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [FW-1:0] f);
    exp_t e;
    for (int i = 0; i < DD; i++) begin
      e.data = f[FW-1-DW*i -: DW];
      e.idx  = 4'(i);
      e.last = (i == DD-1);
      exp_q.push_back(e);
    end
  endtask

  // One frame_valid pulse; expectations queued only if the frame should be kept.
  task automatic send_frame(input logic [FW-1:0] f, input bit accept);
    frame_valid = 1'b1;
    frame_data  = f;
    if (accept) push_expected(f);
    $display("frame %08h accept=%0d", f, accept);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d symbols pending, required 0", exp_q.size());
    end
    tick();
    n_cmp++;
    if (sym_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_drain: got sym_valid=%0b, required 0", sym_valid);
    end
  endtask

  task automatic test_reset();
    frame_valid = 1'b0;
    frame_data  = '0;
    sym_ready   = 1'b0;
    do_reset();
    tick();
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, required 0", sym_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
    n_cmp++; if (sym_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b, required 0", sym_last); end
    n_cmp++; if (sym_index !== 4'd0) begin n_err++; $display("FAIL reset_index: got %0d, required 0", sym_index); end
    n_cmp++; if (sym_data !== 2'd0) begin n_err++; $display("FAIL reset_data: got %0d, required 0", sym_data); end
  endtask

  task automatic test_single();
    sym_ready = 1'b1;
    send_frame(32'hE4E4_E4E4, 1'b1);
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got sym_valid=%0b after push edge, required 0", sym_valid); end
    tick();
    n_cmp++; if (sym_valid !== 1'b1) begin n_err++; $display("FAIL latency: got sym_valid=%0b after pop edge, required 1", sym_valid); end
    n_cmp++; if (sym_data !== 2'd3) begin n_err++; $display("FAIL first_symbol: got %0d, required 3", sym_data); end
    drain();
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    sym_ready = 1'b1;
    send_frame(FW'($urandom), 1'b1);
    for (int i = 0; i < 40 && !(sym_valid && sym_index == 4'd7); i++) tick();
    sym_ready = 1'b0;
    held = sym_data;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (sym_valid !== 1'b1 || sym_index !== 4'd7 || sym_data !== held) begin
        n_err++;
        $display("FAIL stall_hold: got valid=%0b index=%0d data=%0d, required valid=1 index=7 data=%0d",
                 sym_valid, sym_index, sym_data, held);
      end
    end
    sym_ready = 1'b1;
    tick();
    n_cmp++; if (sym_index !== 4'd8) begin n_err++; $display("FAIL stall_resume: got index=%0d, required 8", sym_index); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    int cnt = 0;
    int first = -1;
    int last = -1;
    fa = FW'($urandom);
    fb = FW'($urandom);
    sym_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) begin
        frame_valid = 1'b1; frame_data = fa; push_expected(fa);
        $display("frame %08h accept=1", fa);
      end else if (c == 3) begin
        frame_valid = 1'b1; frame_data = fb; push_expected(fb);
        $display("frame %08h accept=1", fb);
      end else begin
        frame_valid = 1'b0;
      end
      tick();
      if (sym_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL b2b_count: got %0d valid cycles, required 32", cnt); end
    n_cmp++; if (last - first + 1 != 32) begin n_err++; $display("FAIL b2b_contiguous: got span %0d, required 32", last - first + 1); end
    n_cmp++; if (first != 1) begin n_err++; $display("FAIL b2b_latency: got first valid at cycle %0d, required 1", first); end
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    sym_ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      send_frame(FW'($urandom), f < 5);
      if (f == 3) begin
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL ovf_count4: got %0d, required 3", fifo_count); end
      end
      if (f == 4) begin
        n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count5: got %0d, required 4", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %0b, required 0", overflow); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b, required 1", overflow); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count6: got %0d, required 4", fifo_count); end
    sym_ready = 1'b1;
    drain();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b, required 1", overflow); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL ovf_drained: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_full_pop();
    do_reset();
    sym_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(FW'($urandom), 1'b1);
    n_cmp++; if (fifo_count !== 3'(FD)) begin n_err++; $display("FAIL fullpop_full: got %0d, required %0d", fifo_count, FD); end
    sym_ready = 1'b1;
    for (int i = 0; i < 40 && !(sym_valid && sym_last); i++) tick();
    send_frame(FW'($urandom), 1'b1);
    n_cmp++; if (fifo_count !== 3'(FD)) begin n_err++; $display("FAIL fullpop_count: got %0d, required %0d", fifo_count, FD); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %0b, required 0", overflow); end
    n_cmp++; if (sym_valid !== 1'b1 || sym_index !== 4'd0) begin n_err++; $display("FAIL fullpop_chain: got valid=%0b index=%0d, required valid=1 index=0", sym_valid, sym_index); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sym_ready = 1'b1;
    send_frame(FW'($urandom), 1'b1);
    send_frame(FW'($urandom), 1'b1);
    for (int i = 0; i < 40 && !(sym_valid && sym_index == 4'd5); i++) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b, required 0", sym_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d, required 0", fifo_count); end
    tick(); tick(); tick();
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL midrst_discard: got %0b, required 0", sym_valid); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
